// File: rtl/imm_ext_stage.sv
// Registered immediate extender (zero/sign/upper/branch) behind a valid/ready handshake.
// Define IMM_EXT_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module imm_ext_stage #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int unsigned UpShift = OUT_W - IN_W;

    typedef enum logic [1:0] {
        ModeZero   = 2'd0,
        ModeSign   = 2'd1,
        ModeUpper  = 2'd2,
        ModeBranch = 2'd3
    } mode_e;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    mode_e            mode;

    assign mode = mode_e'(in_mode);

    // Extension happens before the register so only the OUT_W result is stored.
    always_comb begin
        zext = OUT_W'(in_imm);
        sext = OUT_W'($signed(in_imm));
        ext  = zext;
        unique case (mode)
            ModeZero:   ext = zext;
            ModeSign:   ext = sext;
            ModeUpper:  ext = zext << UpShift;
            ModeBranch: ext = sext << 2;
            default:    ext = zext;
        endcase
    end

    logic take_in;
    logic take_out;

    // A flushing cycle never captures input.
    assign take_in  = in_valid && in_ready && !flush;
    assign take_out = out_valid && out_ready;

`ifdef IMM_EXT_SKID_EN

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] main_data_q, main_data_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (main_valid_q && !take_out) begin
            // Main is stalled: a new arrival parks in the skid register.
            if (take_in) begin
                skid_valid_d = 1'b1;
                skid_data_d  = ext;
            end
        end else if (skid_valid_q) begin
            // in_ready is low while skid is full, so no input competes here.
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (take_in) begin
            main_valid_d = 1'b1;
            main_data_d  = ext;
        end else begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

`else

    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (take_in) begin
            valid_d = 1'b1;
            data_d  = ext;
        end else if (take_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Single slot: refill in the same cycle the consumer drains it.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

`endif

endmodule
